ws2812_multi_tx: RTL and testbench

- Parametrised successor to the single-channel 8-bit WS2812 serializer.
- Drives CHANNELS independent LED strings in lockstep. Each word is WORD_WIDTH bits per channel, e.g. 24 for a full GRB pixel.
- Bit timing and latch duration are set by parameters.
- Upstream uses a valid/ready stream with a one-word holding buffer, so consecutive words go out with no gap. A latch (strip reset) is requested in-band on the same stream.

---
 rtl/ws2812_multi_tx.sv | 176 +++++++++++++++++
 tb/tb_ws2812_multi_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_multi_tx.sv
// ws2812_multi_tx
//   Multi-channel WS2812 serializer. CHANNELS strings are driven in lockstep
//   from one shared bit/phase sequencer; each channel only contributes its own
//   data bit to the pulse-width decision. Upstream feeds a valid/ready stream
//   through a one-item holding buffer so consecutive words are contiguous.
//   A latch (strip reset: RESET_CYCLES of low) is requested in-band.
//
// Ports
//   clk       clock
//   reset     synchronous active-low reset
//   in_data   CHANNELS*WORD_WIDTH; channel c at [c*WORD_WIDTH +: WORD_WIDTH]
//   in_latch  1 = latch request (in_data ignored), 0 = data word
//   in_valid  upstream item valid
//   in_ready  holding buffer empty (0 while reset is asserted)
//   dout      registered encoded serial outputs, one per channel
//   busy      buffer occupied or sequencer not idle

// Per-channel pulse decision for the slot the sequencer is about to show.
module ws2812_lane #(
    parameter int WORD_WIDTH = 24,
    parameter int T0H        = 1,
    parameter int T1H        = 3,
    parameter int MSB_FIRST  = 1,
    parameter int BW         = 5,
    parameter int PW         = 3
) (
    input  logic [WORD_WIDTH-1:0] word,
    input  logic [BW-1:0]         bit_idx,
    input  logic [PW-1:0]         phase,
    input  logic                  en,
    output logic                  level
);
    logic [BW-1:0] sel_idx;
    logic          cur;

    always_comb begin
        sel_idx = (MSB_FIRST != 0) ? BW'(WORD_WIDTH - 1) - bit_idx : bit_idx;
        cur     = word[sel_idx];
        level   = en && (phase < (cur ? PW'(T1H) : PW'(T0H)));
    end
endmodule

module ws2812_multi_tx #(
    parameter int CHANNELS     = 2,
    parameter int WORD_WIDTH   = 24,
    parameter int BIT_CYCLES   = 5,
    parameter int T0H          = 1,
    parameter int T1H          = 3,
    parameter int RESET_CYCLES = 20,
    parameter int MSB_FIRST    = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS*WORD_WIDTH-1:0] in_data,
    input  logic                           in_latch,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [CHANNELS-1:0]            dout,
    output logic                           busy
);
    localparam int BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int PW = $clog2(BIT_CYCLES);
    localparam int LW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, DATA, LATCH} state_t;

    state_t                               state_q, state_n;
    logic                                 buf_valid, buf_latch;
    logic [CHANNELS-1:0][WORD_WIDTH-1:0]  buf_data;
    logic [CHANNELS-1:0][WORD_WIDTH-1:0]  word_q, word_n;
    logic [BW-1:0]                        bit_q, bit_n;
    logic [PW-1:0]                        phase_q, phase_n;
    logic [LW-1:0]                        lat_q, lat_n;
    logic                                 load, accept, last_word, last_lat;
    logic [CHANNELS-1:0]                  lane_level;

    // Gated by reset so the stream stalls while reset is held.
    assign in_ready = reset && !buf_valid;
    assign busy     = reset && (buf_valid || state_q != IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_n   = state_q;
        word_n    = word_q;
        bit_n     = bit_q;
        phase_n   = phase_q;
        lat_n     = lat_q;
        load      = 1'b0;
        last_word = (phase_q == PW'(BIT_CYCLES - 1)) && (bit_q == BW'(WORD_WIDTH - 1));
        last_lat  = (lat_q == LW'(RESET_CYCLES - 1));

        case (state_q)
            IDLE: load = buf_valid;
            DATA: begin
                if (last_word) begin
                    load = buf_valid;
                    if (!buf_valid) state_n = IDLE;
                end else if (phase_q == PW'(BIT_CYCLES - 1)) begin
                    phase_n = '0;
                    bit_n   = bit_q + 1'b1;
                end else begin
                    phase_n = phase_q + 1'b1;
                end
            end
            LATCH: begin
                if (last_lat) begin
                    load = buf_valid;
                    if (!buf_valid) state_n = IDLE;
                end else begin
                    lat_n = lat_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (load) begin
            if (buf_latch) begin
                state_n = LATCH;
                lat_n   = '0;
            end else begin
                state_n = DATA;
                word_n  = buf_data;
                bit_n   = '0;
                phase_n = '0;
            end
        end
    end

    // Lanes evaluate the *next* slot position so the registered dout lines up
    // with the sequencer state rather than trailing it by a cycle.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        ws2812_lane #(
            .WORD_WIDTH (WORD_WIDTH),
            .T0H        (T0H),
            .T1H        (T1H),
            .MSB_FIRST  (MSB_FIRST),
            .BW         (BW),
            .PW         (PW)
        ) u_lane (
            .word    (word_n[c]),
            .bit_idx (bit_n),
            .phase   (phase_n),
            .en      (state_n == DATA),
            .level   (lane_level[c])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            buf_valid <= 1'b0;
            buf_latch <= 1'b0;
            buf_data  <= '0;
            word_q    <= '0;
            bit_q     <= '0;
            phase_q   <= '0;
            lat_q     <= '0;
            dout      <= '0;
        end else begin
            state_q <= state_n;
            word_q  <= word_n;
            bit_q   <= bit_n;
            phase_q <= phase_n;
            lat_q   <= lat_n;
            dout    <= lane_level;
            // load needs a full buffer and accept an empty one: never both
            if (load) begin
                buf_valid <= 1'b0;
            end else if (accept) begin
                buf_valid <= 1'b1;
                buf_latch <= in_latch;
                buf_data  <= in_data;
            end
        end
    end
endmodule

// File: tb/tb_ws2812_multi_tx.sv
// tb_ws2812_multi_tx
//   Directed bench: two instances (2-channel MSB-first, 1-channel LSB-first,
//   both 8-bit words). Waveforms are captured per cycle and each 5-cycle slot
//   is compared against hand-computed pulse widths.
module tb_ws2812_multi_tx;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_latch, in_valid, in_ready, busy;
    logic [1:0]  dout;
    logic [7:0]  l_data;
    logic        l_latch, l_valid, l_ready, l_busy;
    logic [0:0]  l_dout;

    always #5 clk = ~clk;

    ws2812_multi_tx #(.CHANNELS(2), .WORD_WIDTH(8)) u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_latch(in_latch),
        .in_valid(in_valid), .in_ready(in_ready), .dout(dout), .busy(busy)
    );

    ws2812_multi_tx #(.CHANNELS(1), .WORD_WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .in_data(l_data), .in_latch(l_latch),
        .in_valid(l_valid), .in_ready(l_ready), .dout(l_dout), .busy(l_busy)
    );

    typedef struct packed {
        logic        lat;
        logic [15:0] data;
    } item_t;

    item_t    q[$];
    bit       feeding;
    int       nvec, nerr;
    logic [2:0] wave [0:127];
    logic       rdy_w[0:127];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic present();
        if (feeding) begin
            if (q.size() > 0) begin
                in_valid = 1'b1;
                in_latch = q[0].lat;
                in_data  = q[0].data;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    // One clock; the feeder pops the head item if it was handshaken.
    task automatic tick();
        logic take;
        take = in_valid && in_ready;
        clk1();
        if (take && feeding && q.size() > 0) void'(q.pop_front());
        present();
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            wave[i]  = {l_dout, dout};
            rdy_w[i] = in_ready;
            tick();
        end
    endtask

    // w: one nibble per slot, slot 0 in the top nibble, value = high width.
    task automatic chk_slots(input string tag, input int start, input int ch, input logic [31:0] w);
        int         wd;
        logic [4:0] pat, e;
        for (int s = 0; s < 8; s++) begin
            wd = int'(w[31-4*s -: 4]);
            for (int p = 0; p < 5; p++) pat[4-p] = wave[start + 5*s + p][ch];
            e = 5'((32'd1 << wd) - 1);
            e = e << (5 - wd);
            chk($sformatf("%s s%0d", tag, s), 32'(pat), 32'(e));
        end
    endtask

    initial begin
        logic acc_d, acc_b, z;
        nvec = 0; nerr = 0; feeding = 0;
        reset = 1'b0; in_valid = 1'b1; in_data = '1; in_latch = 1'b0;
        l_valid = 1'b0; l_data = '0; l_latch = 1'b0;

        // Reset with valid asserted: nothing may be accepted.
        for (int i = 0; i < 3; i++) begin
            clk1();
            chk("rst dout", 32'(dout), 0);
            chk("rst rdy",  32'(in_ready), 0);
            chk("rst busy", 32'(busy), 0);
        end
        reset = 1'b1; in_valid = 1'b0;
        #1;
        chk("rel rdy", 32'(in_ready), 1);
        clk1();
        chk("rel busy", 32'(busy), 0);
        chk("rel rdy2", 32'(in_ready), 1);

        // Single word: ch0=0xA5, ch1=0x00.
        feeding = 1;
        q.push_back('{lat: 1'b0, data: 16'h00A5});
        present();
        tick();
        chk("t2 busy", 32'(busy), 1);
        tick();
        capture(40);
        chk_slots("t2 ch0", 0, 0, 32'h31311313);
        chk_slots("t2 ch1", 0, 1, 32'h11111111);
        chk("t2 end dout", 32'(dout), 0);
        chk("t2 end busy", 32'(busy), 0);

        // Back-to-back words, valid held.
        q.push_back('{lat: 1'b0, data: 16'hAA55});
        q.push_back('{lat: 1'b0, data: 16'h00FF});
        present();
        tick();
        tick();
        capture(80);
        chk_slots("t3 w1 ch0", 0, 0, 32'h13131313);
        chk_slots("t3 w1 ch1", 0, 1, 32'h31313131);
        chk_slots("t3 w2 ch0", 40, 0, 32'h33333333);
        chk_slots("t3 w2 ch1", 40, 1, 32'h11111111);
        chk("t3 rdy0",  32'(rdy_w[0]), 1);
        chk("t3 rdy1",  32'(rdy_w[1]), 0);
        chk("t3 rdy39", 32'(rdy_w[39]), 0);
        chk("t3 rdy40", 32'(rdy_w[40]), 1);
        chk("t3 end busy", 32'(busy), 0);

        // Word, latch, word.
        q.push_back('{lat: 1'b0, data: 16'h0001});
        q.push_back('{lat: 1'b1, data: 16'hFFFF});
        q.push_back('{lat: 1'b0, data: 16'h0080});
        present();
        tick();
        tick();
        capture(100);
        chk_slots("t4 w1", 0, 0, 32'h11111113);
        z = 1'b0;
        for (int i = 40; i < 60; i++) z |= |wave[i][1:0];
        chk("t4 latch low", 32'(z), 0);
        chk("t4 w3 pre",   32'(wave[59][0]), 0);
        chk("t4 w3 start", 32'(wave[60][0]), 1);
        chk_slots("t4 w3", 60, 0, 32'h31111111);
        chk("t4 end busy", 32'(busy), 0);

        // Reset at cycle 12 of a word with a second word buffered.
        q.push_back('{lat: 1'b0, data: 16'h00FF});
        q.push_back('{lat: 1'b0, data: 16'h000F});
        present();
        tick();
        tick();
        for (int i = 0; i < 12; i++) tick();
        chk("t5 pre dout", 32'(dout[0]), 1);
        chk("t5 pre rdy",  32'(in_ready), 0);
        reset = 1'b0; feeding = 0; in_valid = 1'b0; q.delete();
        clk1();
        chk("t5 rst dout", 32'(dout), 0);
        chk("t5 rst busy", 32'(busy), 0);
        chk("t5 rst rdy",  32'(in_ready), 0);
        reset = 1'b1;
        clk1();
        chk("t5 rel busy", 32'(busy), 0);
        chk("t5 rel rdy",  32'(in_ready), 1);
        acc_d = 1'b0; acc_b = 1'b0;
        for (int i = 0; i < 60; i++) begin
            acc_d |= |dout;
            acc_b |= busy;
            clk1();
        end
        chk("t5 quiet dout", 32'(acc_d), 0);
        chk("t5 quiet busy", 32'(acc_b), 0);

        // LSB-first instance, word 0x01.
        l_data = 8'h01; l_valid = 1'b1;
        #1;
        chk("t6 rdy", 32'(l_ready), 1);
        clk1();
        l_valid = 1'b0;
        clk1();
        capture(40);
        chk_slots("t6 lsb", 0, 2, 32'h31111111);
        chk("t6 end busy", 32'(l_busy), 0);
        chk("t6 end dout", 32'(l_dout), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
